// File: rtl/systolic_array_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array controller.
// Covers the sequencer state encoding, flush length and phase-counter width.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int flush_len(input int s_height, input int s_width);
    return s_height + s_width - 1;
  endfunction

  // One counter serves both FLUSH and DRAIN, so it must cover the longer of the two.
  function automatic int phase_cnt_w(input int s_height, input int s_width);
    int m;
    m = flush_len(s_height, s_width);
    if (s_width > m) m = s_width;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Operand handshake plus array control bundle between host, controller and array.
// slave = controller side, master = operand source / observer side.
interface sa_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int S_WIDTH    = 2,
  parameter int S_HEIGHT   = 2,
  parameter int K_WIDTH    = 8
);
  logic                           i_start;
  logic [K_WIDTH-1:0]             i_k;
  logic                           i_relu_en;
  logic                           i_valid;
  logic                           o_ready;
  logic [S_HEIGHT*DATA_WIDTH-1:0] i_ifmap_vec;
  logic [S_WIDTH*DATA_WIDTH-1:0]  i_weight_vec;
  logic [S_HEIGHT*DATA_WIDTH-1:0] o_ifmap;
  logic [S_WIDTH*DATA_WIDTH-1:0]  o_weight;
  logic                           o_reg_clear;
  logic                           o_pe_en;
  logic                           o_relu_en;
  logic                           o_psum_out_en;
  logic                           o_busy;
  logic                           o_done;

  modport master (
    output i_start, i_k, i_relu_en, i_valid, i_ifmap_vec, i_weight_vec,
    input  o_ready, o_ifmap, o_weight, o_reg_clear, o_pe_en, o_relu_en,
           o_psum_out_en, o_busy, o_done
  );

  modport slave (
    input  i_start, i_k, i_relu_en, i_valid, i_ifmap_vec, i_weight_vec,
    output o_ready, o_ifmap, o_weight, o_reg_clear, o_pe_en, o_relu_en,
           o_psum_out_en, o_busy, o_done
  );
endinterface

// File: rtl/systolic_array_ctrl_skew_delay.sv
// Enabled shift line of DEPTH stages with synchronous clear; DEPTH=0 is a plain wire.
// Latency DEPTH enabled cycles; holds contents while i_en is low.
module skew_delay #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic [DATA_WIDTH-1:0] o_dat
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{i_clk, i_nrst, i_en, i_clr};
    assign o_dat = i_dat;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (i_clr) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (i_en) begin
        stage[0] <= i_dat;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign o_dat = stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for the systolic array: clear, skewed K-beat feed, zero flush, psum drain, done.
// Done lands K+FLUSH_LEN+S_WIDTH+2 cycles after start; stalls on i_valid freeze the array.
module systolic_array_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int S_WIDTH    = 2,
  parameter int S_HEIGHT   = 2,
  parameter int K_WIDTH    = 8
) (
  input logic   i_clk,
  input logic   i_nrst,
  sa_ctrl_if.slave bus
);

  localparam int FLUSH_LEN = flush_len(S_HEIGHT, S_WIDTH);
  localparam int PW        = phase_cnt_w(S_HEIGHT, S_WIDTH);
  localparam logic [PW-1:0] FLUSH_LAST = PW'(FLUSH_LEN - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(S_WIDTH - 1);

  state_e             state;
  logic [K_WIDTH-1:0] k_q;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [PW-1:0]      phase_cnt;
  logic               relu_q;

  logic accept;
  logic pe_en;
  logic reg_clear;

  assign accept    = (state == ST_FEED) && bus.i_valid;
  assign pe_en     = accept || (state == ST_FLUSH);
  assign reg_clear = (state == ST_CLEAR);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= ST_IDLE;
      k_q       <= '0;
      beat_cnt  <= '0;
      phase_cnt <= '0;
      relu_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            k_q    <= bus.i_k;
            relu_q <= bus.i_relu_en;
            state  <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          beat_cnt  <= '0;
          phase_cnt <= '0;
          state     <= (k_q == '0) ? ST_DONE : ST_FEED;
        end
        ST_FEED: begin
          // Compare before incrementing so K = 2^K_WIDTH-1 never wraps the counter.
          if (accept) begin
            if (beat_cnt == k_q - 1'b1) state <= ST_FLUSH;
            else                        beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (phase_cnt == FLUSH_LAST) begin
            phase_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (phase_cnt == DRAIN_LAST) begin
            phase_cnt <= '0;
            state     <= ST_DONE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready       = (state == ST_FEED);
  assign bus.o_pe_en       = pe_en;
  assign bus.o_reg_clear   = reg_clear;
  assign bus.o_psum_out_en = (state == ST_DRAIN);
  assign bus.o_done        = (state == ST_DONE);
  assign bus.o_busy        = (state != ST_IDLE);
  assign bus.o_relu_en     = relu_q && (state != ST_IDLE);

  // Lane 0 sees the accepted beat or zero, which also provides the flush zeros.
  logic [S_HEIGHT*DATA_WIDTH-1:0] if_in;
  logic [S_WIDTH*DATA_WIDTH-1:0]  wt_in;
  logic [S_HEIGHT*DATA_WIDTH-1:0] if_out;
  logic [S_WIDTH*DATA_WIDTH-1:0]  wt_out;

  assign if_in = accept ? bus.i_ifmap_vec  : '0;
  assign wt_in = accept ? bus.i_weight_vec : '0;

  for (genvar r = 0; r < S_HEIGHT; r++) begin : g_if_skew
    skew_delay #(.DEPTH(r), .DATA_WIDTH(DATA_WIDTH)) u_dly (
      .i_clk (i_clk),
      .i_nrst(i_nrst),
      .i_en  (pe_en),
      .i_clr (reg_clear),
      .i_dat (if_in[r*DATA_WIDTH +: DATA_WIDTH]),
      .o_dat (if_out[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  for (genvar c = 0; c < S_WIDTH; c++) begin : g_wt_skew
    skew_delay #(.DEPTH(c), .DATA_WIDTH(DATA_WIDTH)) u_dly (
      .i_clk (i_clk),
      .i_nrst(i_nrst),
      .i_en  (pe_en),
      .i_clr (reg_clear),
      .i_dat (wt_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_dat (wt_out[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.o_ifmap  = if_out;
  assign bus.o_weight = wt_out;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: cycle-window timing model plus an array model that
// accumulates psums from the skewed streams and compares them with a plain matrix product.
module tb_systolic_array_ctrl;
  localparam int DW   = 8;
  localparam int SW   = 2;
  localparam int SH   = 2;
  localparam int KW   = 8;
  localparam int FL   = SH + SW - 1;
  localparam int MAXC = 1024;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  sa_ctrl_if #(.DATA_WIDTH(DW), .S_WIDTH(SW), .S_HEIGHT(SH), .K_WIDTH(KW)) bus ();

  systolic_array_ctrl #(.DATA_WIDTH(DW), .S_WIDTH(SW), .S_HEIGHT(SH), .K_WIDTH(KW)) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] a_beat [256][SH];
  logic [DW-1:0] w_beat [256][SW];
  int            gap    [256];

  int ifh [SH][MAXC];
  int wh  [SW][MAXC];
  int n_en;
  logic [SH*DW-1:0] if_trace [MAXC];

  int bad_ready, bad_pe, bad_clear, bad_drain, bad_done, bad_busy, bad_relu;
  int bad_hold, bad_abort, n_done_seen, done_seen_cyc, done_exp;

  function automatic int ref_psum(input int k, input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += int'(a_beat[i][r]) * int'(w_beat[i][c]);
    return s;
  endfunction

  // PE(r,c) sees ifmap row r after c hops and weight column c after r hops.
  function automatic int arr_psum(input int r, input int c);
    int s;
    s = 0;
    for (int t = 0; t < n_en; t++)
      if (t - c >= 0 && t - r >= 0) s += ifh[r][t-c] * wh[c][t-r];
    return s;
  endfunction

  function automatic logic [38:0] all_outs();
    return {bus.o_ready, bus.o_ifmap, bus.o_weight, bus.o_reg_clear, bus.o_pe_en,
            bus.o_relu_en, bus.o_psum_out_en, bus.o_busy, bus.o_done};
  endfunction

  task automatic clear_gaps();
    for (int i = 0; i < 256; i++) gap[i] = 0;
  endtask

  task automatic rand_data(input int k);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < SH; r++) a_beat[i][r] = DW'($urandom_range(0, 255));
      for (int c = 0; c < SW; c++) w_beat[i][c] = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic nominal_data();
    a_beat[0][0] = 8'd1; a_beat[0][1] = 8'd0;
    a_beat[1][0] = 8'd2; a_beat[1][1] = 8'd3;
    w_beat[0][0] = 8'd1; w_beat[0][1] = 8'd0;
    w_beat[1][0] = 8'd3; w_beat[1][1] = 8'd2;
  endtask

  // Drives one operation from a precomputed valid schedule and tallies deviations
  // from the expected per-cycle control windows.
  task automatic run_op(input int k, input bit relu, input bit spam, input int abort_cyc);
    bit vs [MAXC];
    int bi [MAXC];
    int c, sumg, feed_end;
    bit e_ready, e_pe, e_clear, e_drain, e_done, e_busy, e_relu, stall, prev_stall;
    logic [SH*DW-1:0] prev_if;
    logic [SW*DW-1:0] prev_w;
    for (int i = 0; i < MAXC; i++) begin vs[i] = 1'b1; bi[i] = -1; end
    sumg = 0; c = 2;
    for (int b = 0; b < k; b++) begin
      for (int g = 0; g < gap[b]; g++) begin vs[c] = 1'b0; c++; end
      bi[c] = b; c++;
      sumg += gap[b];
    end
    feed_end = 1 + sumg + k;
    done_exp = (k == 0) ? 2 : feed_end + FL + SW + 1;
    bad_ready = 0; bad_pe = 0; bad_clear = 0; bad_drain = 0; bad_done = 0;
    bad_busy = 0; bad_relu = 0; bad_hold = 0; bad_abort = 0;
    n_done_seen = 0; done_seen_cyc = -1; n_en = 0;
    prev_stall = 1'b0; prev_if = '0; prev_w = '0;
    for (int cyc = 0; cyc <= done_exp + 3; cyc++) begin
      @(posedge clk); #1;
      bus.i_start = (cyc == 0) || (spam && cyc <= done_exp);
      if (cyc == 0) begin
        bus.i_k = KW'(k); bus.i_relu_en = relu;
      end else begin
        bus.i_k = KW'($urandom); bus.i_relu_en = 1'($urandom);
      end
      bus.i_valid = vs[cyc];
      if (bi[cyc] >= 0) begin
        for (int r = 0; r < SH; r++) bus.i_ifmap_vec[r*DW +: DW] = a_beat[bi[cyc]][r];
        for (int q = 0; q < SW; q++) bus.i_weight_vec[q*DW +: DW] = w_beat[bi[cyc]][q];
      end else begin
        bus.i_ifmap_vec  = (SH*DW)'($urandom);
        bus.i_weight_vec = (SW*DW)'($urandom);
      end
      #3;
      e_ready = (k > 0) && cyc >= 2 && cyc <= feed_end;
      e_pe    = (e_ready && vs[cyc]) || ((k > 0) && cyc > feed_end && cyc <= feed_end + FL);
      e_clear = (cyc == 1);
      e_drain = (k > 0) && cyc > feed_end + FL && cyc <= feed_end + FL + SW;
      e_done  = (cyc == done_exp);
      e_busy  = cyc >= 1 && cyc <= done_exp;
      e_relu  = e_busy && relu;
      if (bus.o_ready       !== e_ready) bad_ready++;
      if (bus.o_pe_en       !== e_pe)    bad_pe++;
      if (bus.o_reg_clear   !== e_clear) bad_clear++;
      if (bus.o_psum_out_en !== e_drain) bad_drain++;
      if (bus.o_done        !== e_done)  bad_done++;
      if (bus.o_busy        !== e_busy)  bad_busy++;
      if (bus.o_relu_en     !== e_relu)  bad_relu++;
      if (bus.o_done === 1'b1) begin
        n_done_seen++;
        if (done_seen_cyc < 0) done_seen_cyc = cyc;
      end
      if (bus.o_pe_en === 1'b1 && n_en < MAXC) begin
        for (int r = 0; r < SH; r++) ifh[r][n_en] = int'(bus.o_ifmap[r*DW +: DW]);
        for (int q = 0; q < SW; q++) wh[q][n_en]  = int'(bus.o_weight[q*DW +: DW]);
        n_en++;
      end
      if (cyc < MAXC) if_trace[cyc] = bus.o_ifmap;
      stall = e_ready && !vs[cyc];
      if (stall && (bus.o_ifmap[DW-1:0] !== '0 || bus.o_weight[DW-1:0] !== '0)) bad_hold++;
      if (prev_stall && ((bus.o_ifmap >> DW) !== (prev_if >> DW) ||
                         (bus.o_weight >> DW) !== (prev_w >> DW))) bad_hold++;
      prev_stall = stall; prev_if = bus.o_ifmap; prev_w = bus.o_weight;
      if (cyc == abort_cyc) begin
        #2 nrst = 1'b0;
        #1 if (all_outs() !== '0) bad_abort++;
        bus.i_start = 1'b0;
        repeat (3) begin
          @(posedge clk); #4;
          if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) bad_abort++;
          if (bus.o_done === 1'b1) n_done_seen++;
        end
        @(posedge clk); #2 nrst = 1'b1;
        break;
      end
    end
    bus.i_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0; bus.i_k = '0; bus.i_relu_en = 1'b0; bus.i_valid = 1'b0;
    bus.i_ifmap_vec = '0; bus.i_weight_vec = '0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", all_outs());
    end
    @(posedge clk); #2 nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.i_valid = 1'b1; bus.i_ifmap_vec = (SH*DW)'($urandom);
      #3;
      n_checks++;
      if (all_outs() !== '0) begin
        n_fail++; $display("FAIL idle_outputs cycle %0d: got %h required 0", i, all_outs());
      end
    end
  endtask

  task automatic test_nominal();
    int exp_p [SH][SW];
    exp_p = '{'{7, 4}, '{9, 6}};
    clear_gaps(); nominal_data();
    run_op(2, 1'b0, 1'b0, -1);
    n_checks++;
    if (bad_ready + bad_pe + bad_clear + bad_drain + bad_done + bad_busy + bad_relu != 0) begin
      n_fail++;
      $display("FAIL nominal_timing: ready %0d pe %0d clear %0d drain %0d done %0d busy %0d relu %0d bad cycles, required 0",
               bad_ready, bad_pe, bad_clear, bad_drain, bad_done, bad_busy, bad_relu);
    end
    n_checks++;
    if (done_seen_cyc != 9) begin
      n_fail++; $display("FAIL nominal_done_cycle: got %0d required 9", done_seen_cyc);
    end
    n_checks++;
    if (if_trace[2][2*DW-1:DW] !== 8'd0 || if_trace[3][2*DW-1:DW] !== 8'd0 ||
        if_trace[4][2*DW-1:DW] !== 8'd3) begin
      n_fail++;
      $display("FAIL nominal_row1_skew: got %0d,%0d,%0d required 0,0,3",
               if_trace[2][2*DW-1:DW], if_trace[3][2*DW-1:DW], if_trace[4][2*DW-1:DW]);
    end
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        n_checks++;
        if (arr_psum(r, c) != exp_p[r][c]) begin
          n_fail++; $display("FAIL nominal_psum[%0d][%0d]: got %0d required %0d", r, c, arr_psum(r, c), exp_p[r][c]);
        end
      end
  endtask

  task automatic test_stall();
    clear_gaps(); nominal_data();
    gap[1] = 2;
    run_op(2, 1'b1, 1'b0, -1);
    n_checks++;
    if (done_seen_cyc != 11) begin
      n_fail++; $display("FAIL stall_done_cycle: got %0d required 11", done_seen_cyc);
    end
    n_checks++;
    if (bad_hold + bad_pe + bad_ready + bad_relu != 0) begin
      n_fail++; $display("FAIL stall_hold: hold %0d pe %0d ready %0d relu %0d bad, required 0",
                         bad_hold, bad_pe, bad_ready, bad_relu);
    end
    n_checks++;
    if (arr_psum(0, 0) != 7 || arr_psum(0, 1) != 4 || arr_psum(1, 0) != 9 || arr_psum(1, 1) != 6) begin
      n_fail++; $display("FAIL stall_psum: got %0d %0d %0d %0d required 7 4 9 6",
                         arr_psum(0, 0), arr_psum(0, 1), arr_psum(1, 0), arr_psum(1, 1));
    end
  endtask

  task automatic test_k0();
    clear_gaps();
    run_op(0, 1'b1, 1'b0, -1);
    n_checks++;
    if (done_seen_cyc != 2 || n_done_seen != 1) begin
      n_fail++; $display("FAIL k0_done: cycle %0d count %0d, required cycle 2 count 1", done_seen_cyc, n_done_seen);
    end
    n_checks++;
    if (n_en != 0 || bad_drain != 0 || bad_clear != 0 || bad_ready != 0) begin
      n_fail++; $display("FAIL k0_controls: pe cycles %0d drain bad %0d clear bad %0d ready bad %0d, required 0",
                         n_en, bad_drain, bad_clear, bad_ready);
    end
  endtask

  task automatic test_start_busy();
    clear_gaps(); rand_data(3);
    run_op(3, 1'b0, 1'b1, -1);
    n_checks++;
    if (n_done_seen != 1 || done_seen_cyc != done_exp) begin
      n_fail++; $display("FAIL busy_start_done: count %0d cycle %0d, required count 1 cycle %0d",
                         n_done_seen, done_seen_cyc, done_exp);
    end
    n_checks++;
    if (bad_ready + bad_pe + bad_drain + bad_busy + bad_relu != 0) begin
      n_fail++; $display("FAIL busy_start_timing: ready %0d pe %0d drain %0d busy %0d relu %0d bad, required 0",
                         bad_ready, bad_pe, bad_drain, bad_busy, bad_relu);
    end
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        n_checks++;
        if (arr_psum(r, c) != ref_psum(3, r, c)) begin
          n_fail++; $display("FAIL busy_start_psum[%0d][%0d]: got %0d required %0d", r, c, arr_psum(r, c), ref_psum(3, r, c));
        end
      end
  endtask

  task automatic test_reset_mid();
    clear_gaps(); nominal_data();
    run_op(2, 1'b1, 1'b0, 5);
    n_checks++;
    if (bad_abort != 0 || n_done_seen != 0) begin
      n_fail++; $display("FAIL abort_flush: bad %0d dones %0d, required 0 and 0", bad_abort, n_done_seen);
    end
    run_op(2, 1'b0, 1'b0, -1);
    n_checks++;
    if (done_seen_cyc != 9 || n_done_seen != 1) begin
      n_fail++; $display("FAIL abort_restart_done: cycle %0d count %0d, required 9 and 1", done_seen_cyc, n_done_seen);
    end
    n_checks++;
    if (arr_psum(0, 0) != 7 || arr_psum(0, 1) != 4 || arr_psum(1, 0) != 9 || arr_psum(1, 1) != 6) begin
      n_fail++; $display("FAIL abort_restart_psum: got %0d %0d %0d %0d required 7 4 9 6",
                         arr_psum(0, 0), arr_psum(0, 1), arr_psum(1, 0), arr_psum(1, 1));
    end
  endtask

  task automatic test_random();
    int k;
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(1, 12);
      clear_gaps(); rand_data(k);
      for (int b = 0; b < k; b++) gap[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_op(k, 1'($urandom), 1'b0, -1);
      n_checks++;
      if (bad_ready + bad_pe + bad_clear + bad_drain + bad_done + bad_busy + bad_relu + bad_hold != 0) begin
        n_fail++;
        $display("FAIL random_timing it %0d k %0d: ready %0d pe %0d clear %0d drain %0d done %0d busy %0d relu %0d hold %0d, required 0",
                 it, k, bad_ready, bad_pe, bad_clear, bad_drain, bad_done, bad_busy, bad_relu, bad_hold);
      end
      for (int r = 0; r < SH; r++)
        for (int c = 0; c < SW; c++) begin
          n_checks++;
          if (arr_psum(r, c) != ref_psum(k, r, c)) begin
            n_fail++; $display("FAIL random_psum it %0d [%0d][%0d]: got %0d required %0d",
                               it, r, c, arr_psum(r, c), ref_psum(k, r, c));
          end
        end
    end
  endtask

  task automatic test_kmax();
    clear_gaps(); rand_data(255);
    run_op(255, 1'b0, 1'b0, -1);
    n_checks++;
    if (done_seen_cyc != 262 || n_done_seen != 1) begin
      n_fail++; $display("FAIL kmax_done: cycle %0d count %0d, required 262 and 1", done_seen_cyc, n_done_seen);
    end
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        n_checks++;
        if (arr_psum(r, c) != ref_psum(255, r, c)) begin
          n_fail++; $display("FAIL kmax_psum[%0d][%0d]: got %0d required %0d", r, c, arr_psum(r, c), ref_psum(255, r, c));
        end
      end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_k0();
    test_start_busy();
    test_reset_mid();
    test_random();
    test_kmax();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
